// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester byte arbiter feeding a UART transmitter, with per-requester sent-byte counters.
// Define UART_ARB_RR_EN for round-robin on simultaneous requests; default build is fixed priority to requester 0.
module uart_tx_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [7:0]       req_data0,
  input  logic [7:0]       req_data1,
  output logic [1:0]       req_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [1:0]       dbg_state
);

  // Handshakes: req_ready[i] is a one-cycle accept pulse, only in IDLE, and the byte on
  // req_data<i> is taken at that edge. tx_valid/tx_data hold steady in SEND and the
  // byte is gone at the first edge with tx_valid && tx_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             grant_q, grant_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             winner;

`ifdef UART_ARB_RR_EN
  // Remembers whether a two-way contest has happened since reset, so the first one goes to requester 0.
  logic contested_q, contested_d;
`endif

  always_comb begin
    winner = 1'b0;
    if (req_valid == 2'b10) begin
      winner = 1'b1;
    end else if (req_valid == 2'b11) begin
`ifdef UART_ARB_RR_EN
      winner = contested_q ? ~grant_q : 1'b0;
`else
      winner = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    req_ready = 2'b00;
`ifdef UART_ARB_RR_EN
    contested_d = contested_q;
`endif
    case (state_q)
      IDLE: begin
        // rst gates the accept pulse so nothing is offered while reset is held.
        if (rst && (req_valid != 2'b00)) begin
          req_ready = winner ? 2'b10 : 2'b01;
          hold_d    = winner ? req_data1 : req_data0;
          grant_d   = winner;
          state_d   = SEND;
`ifdef UART_ARB_RR_EN
          if (req_valid == 2'b11) contested_d = 1'b1;
`endif
        end
      end
      SEND: begin
        if (tx_ready) begin
          state_d = GAP;
          if (grant_q) cnt1_d = cnt1_q + CNT_ONE;
          else         cnt0_d = cnt0_q + CNT_ONE;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= 8'h00;
      grant_q <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
`ifdef UART_ARB_RR_EN
      contested_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
`ifdef UART_ARB_RR_EN
      contested_q <= contested_d;
`endif
    end
  end

  assign tx_valid  = (state_q == SEND);
  assign tx_data   = tx_valid ? hold_q : 8'h00;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model plus scoreboard, directed scenarios, then random traffic.
// Build with +define+UART_ARB_RR_EN to check the round-robin variant.
module tb_uart_tx_arbiter;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [7:0]       req_data0;
  logic [7:0]       req_data1;
  logic [1:0]       req_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             grant_id;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  uart_tx_arbiter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .grant_id  (grant_id),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // A byte is either in flight (owned by m_owner), or the link is cooling down for one
  // cycle, or the arbiter is free to accept.
  logic             m_inflight = 1'b0;
  logic             m_cool     = 1'b0;
  logic [7:0]       m_byte     = 8'h00;
  logic             m_owner    = 1'b0;
  logic             m_seen     = 1'b0;
  logic [CNT_W-1:0] m_cnt [2]  = '{default: '0};
  logic [7:0]       exp_q [$];
  logic [7:0]       acc_q [$];
  logic             saw_rdy1   = 1'b0;

  function automatic logic pick(input logic [1:0] v);
    if (v == 2'b10) return 1'b1;
    if (v == 2'b11) begin
`ifdef UART_ARB_RR_EN
      return m_seen ? ~m_owner : 1'b0;
`else
      return 1'b0;
`endif
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_ready();
    if (!rst || m_inflight || m_cool || req_valid == 2'b00) return 2'b00;
    return pick(req_valid) ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_inflight = 1'b0;
      m_cool     = 1'b0;
      m_byte     = 8'h00;
      m_owner    = 1'b0;
      m_seen     = 1'b0;
      m_cnt[0]   = '0;
      m_cnt[1]   = '0;
      exp_q.delete();
    end else if (m_inflight) begin
      if (tx_ready) begin
        m_cnt[m_owner] = m_cnt[m_owner] + 1'b1;
        m_inflight     = 1'b0;
        m_cool         = 1'b1;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (req_valid != 2'b00) begin
      logic w;
      w          = pick(req_valid);
      m_owner    = w;
      m_byte     = w ? req_data1 : req_data0;
      m_inflight = 1'b1;
      if (req_valid == 2'b11) m_seen = 1'b1;
      exp_q.push_back(m_byte);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_ready()});
    check("tx_valid", {31'd0, tx_valid}, {31'd0, m_inflight});
    check("tx_data", {24'd0, tx_data}, {24'd0, (m_inflight ? m_byte : 8'h00)});
    check("busy", {31'd0, busy}, {31'd0, (m_inflight | m_cool)});
    check("grant_id", {31'd0, grant_id}, {31'd0, m_owner});
    check("cnt0", 32'(cnt0), 32'(m_cnt[0]));
    check("cnt1", 32'(cnt1), 32'(m_cnt[1]));
    if (req_ready[1]) saw_rdy1 = 1'b1;
    if (tx_valid && tx_ready) begin
      acc_q.push_back(tx_data);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_byte: got %0h expected none queued at %0t", tx_data, $time);
      end else begin
        check("sb_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short low pulse wholly inside the high phase, no clock edge while rst is low.
  task automatic do_reset();
    tick();
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    acc_q.delete();
    saw_rdy1 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_data0 = 8'h00;
    req_data1 = 8'h00;
    tx_ready  = 1'b0;
    #1 rst = 1'b0;
    req_valid = 2'b01;
    #1;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    req_valid = 2'b00;
    #10 rst = 1'b1;

    // single byte from requester 0
    tick();
    req_valid = 2'b01; req_data0 = 8'h41; tx_ready = 1'b1;
    #1;
    check("d1_ready", {30'd0, req_ready}, 32'h1);
    check("d1_busy_idle", {31'd0, busy}, 32'd0);
    tick();
    req_valid = 2'b00;
    #1;
    check("d1_ready_once", {30'd0, req_ready}, 32'h0);
    check("d1_tx_valid", {31'd0, tx_valid}, 32'h1);
    check("d1_tx_data", {24'd0, tx_data}, 32'h41);
    tick(); #1;
    check("d1_cnt0", 32'(cnt0), 32'd1);
    check("d1_gap_valid", {31'd0, tx_valid}, 32'd0);
    check("d1_gap_busy", {31'd0, busy}, 32'd1);
    tick(); #1;
    check("d1_idle_busy", {31'd0, busy}, 32'd0);

    // both requesters held for four bytes
    do_reset();
    req_valid = 2'b11; req_data0 = 8'hAA; req_data1 = 8'h55; tx_ready = 1'b1;
    repeat (12) tick();
    req_valid = 2'b00;
    #1;
    check("d2_count", acc_q.size(), 32'd4);
    if (acc_q.size() == 4) begin
`ifdef UART_ARB_RR_EN
      check("d2_b0", {24'd0, acc_q[0]}, 32'hAA);
      check("d2_b1", {24'd0, acc_q[1]}, 32'h55);
      check("d2_b2", {24'd0, acc_q[2]}, 32'hAA);
      check("d2_b3", {24'd0, acc_q[3]}, 32'h55);
      check("d2_cnt0", 32'(cnt0), 32'd2);
      check("d2_cnt1", 32'(cnt1), 32'd2);
`else
      for (int i = 0; i < 4; i++) check("d2_byte", {24'd0, acc_q[i]}, 32'hAA);
      check("d2_cnt0", 32'(cnt0), 32'd4);
      check("d2_cnt1", 32'(cnt1), 32'd0);
      check("d2_no_rdy1", {31'd0, saw_rdy1}, 32'd0);
`endif
    end

    // transmitter stalls while the requester changes its byte
    do_reset();
    req_valid = 2'b01; req_data0 = 8'h5A; tx_ready = 1'b0;
    tick();
    req_valid = 2'b00; req_data0 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("d3_hold_valid", {31'd0, tx_valid}, 32'd1);
      check("d3_hold_data", {24'd0, tx_data}, 32'h5A);
      tick();
    end
    tx_ready = 1'b1;
    #1;
    check("d3_still_valid", {31'd0, tx_valid}, 32'd1);
    check("d3_cnt0_before", 32'(cnt0), 32'd0);
    tick(); #1;
    check("d3_done_valid", {31'd0, tx_valid}, 32'd0);
    check("d3_cnt0_after", 32'(cnt0), 32'd1);

    // counter wrap with a 4-bit counter
    do_reset();
    req_valid = 2'b10; tx_ready = 1'b1;
    for (int b = 1; b <= 17; b++) begin
      req_data1 = 8'($urandom_range(0, 255));
      repeat (3) tick();
      if (b == 15) check("d4_cnt1_15", 32'(cnt1), 32'd15);
      if (b == 16) check("d4_cnt1_16", 32'(cnt1), 32'd0);
      if (b == 17) check("d4_cnt1_17", 32'(cnt1), 32'd1);
    end
    req_valid = 2'b00;

    // reset pulse while a byte is in SEND
    do_reset();
    req_valid = 2'b01; req_data0 = 8'h3C; tx_ready = 1'b0;
    tick();
    #1;
    check("d5_sending", {31'd0, tx_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check("d5_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("d5_rst_busy", {31'd0, busy}, 32'd0);
    check("d5_rst_ready", {30'd0, req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("d5_post_busy", {31'd0, busy}, 32'd0);
    check("d5_post_cnt0", 32'(cnt0), 32'd0);
    check("d5_post_cnt1", 32'(cnt1), 32'd0);
    req_data0 = 8'h77; tx_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    #1;
    check("d5_next_data", {24'd0, tx_data}, 32'h77);
    tick(); #1;
    check("d5_next_cnt0", 32'(cnt0), 32'd1);

    // random traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      tick();
      req_valid = 2'($urandom_range(0, 3));
      req_data0 = 8'($urandom_range(0, 255));
      req_data1 = 8'($urandom_range(0, 255));
      tx_ready  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end
    tick();
    req_valid = 2'b00;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each per-requester byte counter.
REQ-002 SHALL have port clk  input  1  single clock; all state rises on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  2  byte-available flag per requester; bit0 = CPU port, bit1 = debug port.
REQ-005 SHALL have port req_data0  input  8  requester 0 byte.
REQ-006 SHALL have port req_data1  input  8  requester 1 byte.
REQ-007 SHALL have port req_ready  output  2  one-hot accept pulse to the granted requester.
REQ-008 SHALL have port tx_data  output  8  byte to transmitter i_data.
REQ-009 SHALL have port tx_valid  output  1  to transmitter i_valid.
REQ-010 SHALL have port tx_ready  input  1  from transmitter o_ready.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port grant_id  output  1  owner of the byte in flight; last owner when IDLE.
REQ-013 SHALL have port cnt0  output  CNT_W  bytes sent for requester 0.
REQ-014 SHALL have port cnt1  output  CNT_W  bytes sent for requester 1.

Function
REQ-015 SHALL implement FSM with states IDLE, SEND and GAP.
REQ-016 In IDLE with any req_valid bit set, SHALL select winner per REQ-024/REQ-025 and drive req_ready[winner]=1 combinationally in that same cycle.
REQ-017 At the edge ending that cycle, SHALL latch the winner's data into the hold register, set grant_id = winner, and go to SEND.
REQ-018 req_ready SHALL be high only in IDLE, at most one bit at a time, and for at most one cycle per byte.
REQ-019 In SEND, SHALL drive tx_valid=1 and tx_data=hold register, both stable until accepted.
REQ-020 A transfer SHALL complete at the edge where SEND and tx_ready=1; next state GAP.
REQ-021 On completion, cnt[grant_id] SHALL increment by 1 and wrap modulo 2^CNT_W, with no saturation.
REQ-022 GAP SHALL last exactly one cycle with tx_valid=0 and req_ready=0, then go to IDLE.
REQ-023 Minimum spacing SHALL be 3 cycles per byte, with tx_ready already high.
REQ-024 Requester 0 SHALL win when only bit0 is set; requester 1 SHALL win when only bit1 is set.
REQ-025 When both bits are set, the winner SHALL be selected per REQ-032/REQ-033.
REQ-026 A req_valid change during SEND or GAP SHALL have no effect on the byte in flight.
REQ-027 tx_data SHALL be 8'h00 whenever tx_valid=0.

Reset
REQ-028 rst low SHALL immediately clear state to IDLE, hold register to 0, grant_id to 0 and cnt0/cnt1 to 0, independent of clk.
REQ-029 While rst is low, tx_valid, tx_data, req_ready and busy SHALL be 0.
REQ-030 Reset during SEND SHALL drop the byte: tx_valid falls asynchronously, no counter increments, and no retry follows.
REQ-031 After rst deassertion, the first grant SHALL occur no earlier than the first clock edge with rst high.

Configuration
REQ-032 With macro UART_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester other than the current grant_id wins, and the first contest after reset goes to requester 0.
REQ-033 Without UART_ARB_RR_EN, simultaneous requests SHALL be granted to requester 0 (fixed priority), and grant_id SHALL still track the owner.

Verification
REQ-034 Reset, req_valid=2'b01, data0=8'h41, tx_ready=1 -> req_ready=01 for 1 cycle; tx_valid=1 with tx_data=8'h41 next cycle; cnt0=1 after 3 cycles; busy low in cycle 4.
REQ-035 req_valid=2'b11 held with data0=8'hAA and data1=8'h55 for 4 bytes, RR on -> tx sequence AA,55,AA,55 and cnt0=cnt1=2.
REQ-036 Same stimulus as REQ-035 with RR off -> tx sequence AA,AA,AA,AA; cnt0=4; cnt1=0; req_ready[1] never asserted.
REQ-037 tx_ready=0 for 10 cycles in SEND while data0 changes to 8'h00 -> tx_valid stays high and tx_data stays at the latched value; completion occurs on the cycle tx_ready rises.
REQ-038 CNT_W=4 and 17 bytes from requester 1 -> cnt1 reads 15 then 0 then 1.
REQ-039 rst pulsed low mid-SEND between edges -> tx_valid=0 immediately; after release, busy=0 and counters=0; the next request is serviced normally.
